// File: rtl/integer_serializer_if.sv
// Handshake bundle between the integer serializer and its environment.
// Value/start/ready flow into the serializer; char stream and status flow out.
// The character stream uses valid/ready: char_dat is held while char_valid && !ready.
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 10
`endif
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

interface integer_serializer_if;
  logic [`ATTRIBUTE_VAL_BITES-1:0] value;
  logic                            start;
  logic                            ready;
  logic [`CHAR_BITES-1:0]          char_dat;
  logic                            char_valid;
  logic                            busy;
  logic                            has_finished;

  // Serializer side: produces the character stream.
  modport master (
    input  value, start, ready,
    output char_dat, char_valid, busy, has_finished
  );

  // Environment side: supplies the value and consumes characters.
  modport slave (
    output value, start, ready,
    input  char_dat, char_valid, busy, has_finished
  );
endinterface

// File: rtl/integer_serializer.sv
// Binary-to-ASCII-decimal serializer, MSD first, leading zeros suppressed.
// Latency: 1 LOAD + (d+1) DIVIDE cycles per digit d, then EMIT until accepted.
// Backpressure: char_dat/char_valid held stable until ready; start ignored while busy.
// Optional: define INTEGER_SERIALIZER_TERMINATOR_EN to append TERMINATOR after the last digit.
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 10
`endif
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

module integer_serializer #(
  parameter int                     DIGITS     = 4,
  parameter logic [`CHAR_BITES-1:0] TERMINATOR = 8'h20
) (
  input logic                  clock,
  input logic                  resetn,
  integer_serializer_if.master sif
);

  localparam int VW = `ATTRIBUTE_VAL_BITES;
  localparam int CW = `CHAR_BITES;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef INTEGER_SERIALIZER_TERMINATOR_EN
  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, EMIT, TERM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, EMIT, DONE} state_t;
`endif

  // 10^i clamped to 2^VW: a power that exceeds any representable value simply
  // never satisfies the compare, so its digit is always a leading zero.
  function automatic logic [VW:0] pow10(input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) begin
      p = p * 10;
      if (p > (1 << VW)) p = (1 << VW);
    end
    return p[VW:0];
  endfunction

  logic [VW:0] pow_tbl [DIGITS];
  for (genvar g = 0; g < DIGITS; g++) begin : g_pow
    assign pow_tbl[g] = pow10(g);
  end

  state_t        state_q, state_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    digit_q, digit_d;
  logic          seen_q, seen_d;
  logic [CW-1:0] char_q, char_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic [VW:0]   pow_sel;

  assign pow_sel = pow_tbl[idx_q];

  // State and datapath registers; reset aborts any conversion immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      digit_q <= '0;
      seen_q  <= 1'b0;
      char_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      seen_q  <= seen_d;
      char_q  <= char_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state logic: repeated subtraction of 10^idx builds each digit.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    digit_d = digit_q;
    seen_d  = seen_q;
    char_d  = char_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    fin_d   = fin_q;
    case (state_q)
      IDLE, DONE: begin
        if (sif.start) begin
          rem_d   = sif.value;
          idx_d   = IW'(DIGITS - 1);
          seen_d  = 1'b0;
          fin_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        digit_d = '0;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        if ({1'b0, rem_q} >= pow_sel) begin
          rem_d   = rem_q - pow_sel[VW-1:0];
          digit_d = digit_q + 4'd1;
        end else if (digit_q != 4'd0 || seen_q || idx_q == '0) begin
          // The least significant position always emits, so 0 becomes "0".
          char_d  = CW'(8'h30) + CW'(digit_q);
          vld_d   = 1'b1;
          seen_d  = 1'b1;
          state_d = EMIT;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = LOAD;
        end
      end
      EMIT: begin
        if (sif.ready) begin
          if (idx_q == '0) begin
`ifdef INTEGER_SERIALIZER_TERMINATOR_EN
            char_d  = TERMINATOR;
            vld_d   = 1'b1;
            state_d = TERM;
`else
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            state_d = DONE;
`endif
          end else begin
            vld_d   = 1'b0;
            idx_d   = idx_q - 1'b1;
            state_d = LOAD;
          end
        end
      end
`ifdef INTEGER_SERIALIZER_TERMINATOR_EN
      TERM: begin
        if (sif.ready) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign sif.char_dat     = char_q;
  assign sif.char_valid   = vld_q;
  assign sif.busy         = busy_q;
  assign sif.has_finished = fin_q;

endmodule

// File: tb/tb_integer_serializer.sv
// Self-checking bench for integer_serializer: directed scenarios plus random
// values with random ready, checked against a decimal-string reference model.
module tb_integer_serializer;

  logic clock;
  logic resetn;
  int   total;
  int   bad;

  integer_serializer_if sif ();

  integer_serializer dut (
    .clock  (clock),
    .resetn (resetn),
    .sif    (sif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: the decimal text of v, plus the delimiter when compiled in.
  function automatic string exp_str(input int v);
    string s;
    s = $sformatf("%0d", v);
`ifdef INTEGER_SERIALIZER_TERMINATOR_EN
    s = {s, " "};
`endif
    return s;
  endfunction

  // Far-end parser model: accumulate leading decimal digits.
  function automatic int parse_str(input string s);
    int acc;
    acc = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] < "0" || s[i] > "9") break;
      acc = acc * 10 + (s[i] - "0");
    end
    return acc;
  endfunction

  task automatic do_start(input int v);
    logic [31:0] vv;
    vv = v;
    @(negedge clock);
    sif.value = vv[9:0];
    sif.start = 1'b1;
    @(negedge clock);
    sif.start = 1'b0;
  endtask

  // Consume characters until has_finished; reports text, hold violations, timeout.
  task automatic collect(input int max_cyc, input int rdy_pct,
                         output string got, output int unstable, output bit tmo);
    logic       prev_vld;
    logic       prev_acc;
    logic [7:0] prev_char;
    logic       r;
    got = "";
    unstable = 0;
    tmo = 1'b1;
    prev_vld = 1'b0;
    prev_acc = 1'b0;
    prev_char = 8'h00;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clock);
      if (prev_vld && !prev_acc && (sif.char_valid !== 1'b1 || sif.char_dat !== prev_char))
        unstable++;
      if (sif.has_finished === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      r = ($urandom_range(99) < rdy_pct);
      sif.ready = r;
      if (sif.char_valid === 1'b1 && r) got = $sformatf("%s%c", got, sif.char_dat);
      prev_vld = sif.char_valid;
      prev_acc = r;
      prev_char = sif.char_dat;
    end
    sif.ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    sif.value = '0;
    sif.start = 1'b0;
    sif.ready = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({sif.char_dat, sif.char_valid, sif.busy, sif.has_finished} !== 11'd0) begin
      bad++;
      $display("FAIL reset_state: got char=%h vld=%b busy=%b fin=%b, want all 0",
               sif.char_dat, sif.char_valid, sif.busy, sif.has_finished);
    end
    resetn = 1'b1;
    @(negedge clock);
    total++;
    if (sif.busy !== 1'b0 || sif.char_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b vld=%b, want 0 0", sif.busy, sif.char_valid);
    end
  endtask

  task automatic test_value(input string name, input int v, input int pct);
    string got;
    int    unst;
    bit    tmo;
    do_start(v);
    collect(400, pct, got, unst, tmo);
    total++;
    if (tmo) begin
      bad++;
      $display("FAIL %s_timeout: value=%0d no has_finished within budget", name, v);
    end
    total++;
    if (got != exp_str(v)) begin
      bad++;
      $display("FAIL %s_text: value=%0d got \"%s\" want \"%s\"", name, v, got, exp_str(v));
    end
    total++;
    if (unst != 0) begin
      bad++;
      $display("FAIL %s_hold: value=%0d char changed under backpressure %0d times, want 0",
               name, v, unst);
    end
    total++;
    if (sif.busy !== 1'b0 || sif.char_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: busy=%b vld=%b, want 0 0", name, sif.busy, sif.char_valid);
    end
`ifdef INTEGER_SERIALIZER_TERMINATOR_EN
    total++;
    if (parse_str(got) != v) begin
      bad++;
      $display("FAIL %s_loopback: parsed %0d want %0d", name, parse_str(got), v);
    end
`endif
  endtask

  task automatic test_hold;
    bit seen;
    do_start(7);
    sif.ready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (sif.char_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL hold_valid_rise: char_valid never rose for value 7");
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sif.char_valid !== 1'b1 || sif.char_dat !== 8'h37) begin
        bad++;
        $display("FAIL hold_stable: cycle %0d char=%h vld=%b, want 37 1",
                 i, sif.char_dat, sif.char_valid);
      end
      @(negedge clock);
    end
    sif.ready = 1'b1;
    @(negedge clock);
`ifdef INTEGER_SERIALIZER_TERMINATOR_EN
    total++;
    if (sif.char_valid !== 1'b1 || sif.char_dat !== 8'h20) begin
      bad++;
      $display("FAIL hold_term: char=%h vld=%b, want 20 1", sif.char_dat, sif.char_valid);
    end
    @(negedge clock);
`endif
    total++;
    if (sif.has_finished !== 1'b1 || sif.busy !== 1'b0 || sif.char_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_finish: fin=%b busy=%b vld=%b, want 1 0 0",
               sif.has_finished, sif.busy, sif.char_valid);
    end
    sif.ready = 1'b0;
  endtask

  task automatic test_ignore_start;
    string got;
    int    unst;
    bit    tmo;
    @(negedge clock);
    sif.value = 10'd250;
    sif.start = 1'b1;
    @(negedge clock);
    sif.value = 10'd999;
    sif.start = 1'b1;
    sif.ready = 1'b1;
    @(negedge clock);
    sif.start = 1'b0;
    collect(400, 100, got, unst, tmo);
    total++;
    if (tmo || got != exp_str(250)) begin
      bad++;
      $display("FAIL ignore_start: got \"%s\" tmo=%b want \"%s\"", got, tmo, exp_str(250));
    end
    // Restart from DONE clears has_finished on the same edge.
    do_start(999);
    total++;
    if (sif.has_finished !== 1'b0 || sif.busy !== 1'b1) begin
      bad++;
      $display("FAIL done_restart: fin=%b busy=%b, want 0 1", sif.has_finished, sif.busy);
    end
    collect(400, 100, got, unst, tmo);
    total++;
    if (tmo || got != exp_str(999)) begin
      bad++;
      $display("FAIL done_restart_text: got \"%s\" tmo=%b want \"%s\"", got, tmo, exp_str(999));
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    do_start(512);
    sif.ready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (sif.char_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || sif.char_dat !== 8'h35) begin
      bad++;
      $display("FAIL mid_first_char: seen=%b char=%h, want 1 35", seen, sif.char_dat);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (sif.char_valid !== 1'b0 || sif.busy !== 1'b0 || sif.has_finished !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: vld=%b busy=%b fin=%b, want 0 0 0",
               sif.char_valid, sif.busy, sif.has_finished);
    end
    @(negedge clock);
    resetn = 1'b1;
    test_value("after_reset", 42, 100);
  endtask

  task automatic test_random;
    int corner [10];
    int v;
    corner = '{0, 1, 9, 10, 99, 100, 101, 999, 1000, 1023};
    for (int i = 0; i < 10; i++) test_value("corner", corner[i], 70);
    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(1023);
      test_value("random", v, $urandom_range(100, 20));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_value("zero", 0, 100);
    total++;
    if (sif.has_finished !== 1'b1) begin
      bad++;
      $display("FAIL zero_finished: fin=%b, want 1", sif.has_finished);
    end
    test_value("max", 1023, 100);
    test_hold;
    test_ignore_start;
    test_reset_mid;
    test_value("loop1", 1, 100);
    test_value("loop10", 10, 100);
    test_value("loop100", 100, 100);
    test_value("loop1000", 1000, 100);
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
